segment_selector: RTL and testbench

SEGMENT_SELECTOR -- requirements
Module: segment_selector

---
 rtl/mcmc_pkg.sv | 41 ++++
 rtl/lfsr16.sv | 26 ++
 rtl/segment_selector.sv | 212 +++++++++++++++++++++
 tb/tb_segment_selector.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcmc_pkg.sv
// Shared definitions for the MCMC segment selector and the downstream sampler:
// segment type codes, selector FSM states, the segment table record and
// the LFSR step/seed helpers.
package mcmc_pkg;

   // Width of the from/to/weight fields stored in a segment record.
   localparam int SEG_DW = 8;

   typedef enum logic [1:0] {
      SEG_NONE    = 2'd0,
      SEG_EXPDOWN = 2'd1,
      SEG_EXPUP   = 2'd2,
      SEG_UNIFORM = 2'd3
   } seg_type_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCUM  = 3'd1,
      ST_DRAW   = 3'd2,
      ST_SCAN   = 3'd3,
      ST_OUTPUT = 3'd4
   } sel_state_e;

   typedef struct packed {
      logic signed [SEG_DW-1:0] fromVal;
      logic signed [SEG_DW-1:0] toVal;
      seg_type_e                segType;
      logic        [SEG_DW-1:0] weight;
   } seg_t;

   // One Fibonacci step of x^16+x^14+x^13+x^11+1, shifting towards the MSB.
   function automatic logic [15:0] lfsrNext(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // An all-zero state would lock the LFSR, so a zero seed byte becomes 8'h01.
   function automatic logic [15:0] lfsrSeed(input logic [7:0] seed);
      return {((seed == 8'd0) ? 8'h01 : seed), 8'hA5};
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit maximal-length LFSR used as the random source for segment draws.
// Loads its seed while reset is held and advances only when stepped.
module lfsr16
   import mcmc_pkg::*;
(
   input  logic        in_clock,
   input  logic        in_reset,
   input  logic [7:0]  in_seed,
   input  logic        in_step,
   output logic [15:0] out_state
);

   logic [15:0] state_q;

   // State register: seed load on reset, one shift per step request.
   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         state_q <= lfsrSeed(in_seed);
      end else if (in_step) begin
         state_q <= lfsrNext(state_q);
      end
   end

   assign out_state = state_q;

endmodule

// File: rtl/segment_selector.sv
// Weighted segment selector: holds a small table of segments, sums the
// active weights, draws a uniform target below that total from the LFSR
// and returns the first entry whose running weight sum exceeds the target.
module segment_selector
   import mcmc_pkg::*;
#(
   parameter  int MAX_SEGMENTS = 8,
   parameter  int DATA_WIDTH   = SEG_DW,
   localparam int IW           = $clog2(MAX_SEGMENTS),
   localparam int TW           = DATA_WIDTH + IW
) (
   input  logic                         in_clock,
   input  logic                         in_reset,
   input  logic [7:0]                   in_seed,
   input  logic                         in_wr_en,
   input  logic [IW-1:0]                in_wr_index,
   input  logic signed [DATA_WIDTH-1:0] in_wr_from,
   input  logic signed [DATA_WIDTH-1:0] in_wr_to,
   input  logic [1:0]                   in_wr_type,
   input  logic [DATA_WIDTH-1:0]        in_wr_weight,
   input  logic [IW:0]                  in_num_segments,
   input  logic                         in_start,
   input  logic                         in_ready,
   output logic                         out_busy,
   output logic                         out_valid,
   output logic signed [DATA_WIDTH-1:0] out_from,
   output logic signed [DATA_WIDTH-1:0] out_to,
   output logic [1:0]                   out_type,
   output logic signed [DATA_WIDTH-1:0] out_weight,
   output logic [IW-1:0]                out_index,
   output logic                         out_error
);

   localparam logic [IW:0]   MAX_N   = (IW+1)'(MAX_SEGMENTS);
   localparam logic [IW:0]   ONE_N   = (IW+1)'(1);
   localparam logic [IW-1:0] ONE_IDX = IW'(1);

   seg_t segTable_q [MAX_SEGMENTS];

   sel_state_e state_q, state_d;
   logic [IW:0]   numSeg_q, numSeg_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [TW-1:0] total_q, total_d;
   logic [TW-1:0] cum_q, cum_d;
   logic [TW-1:0] target_q, target_d;
   logic          error_q, error_d;

   logic signed [DATA_WIDTH-1:0] from_q, from_d;
   logic signed [DATA_WIDTH-1:0] to_q, to_d;
   seg_type_e                    type_q, type_d;
   logic [DATA_WIDTH-1:0]        weight_q, weight_d;
   logic [IW-1:0]                index_q, index_d;

   seg_t          curEntry;
   logic [TW-1:0] curWeight;
   logic          lastIdx;
   logic          lfsrStep;
   logic [15:0]   lfsrState;
   logic [TW+15:0] drawProduct;

   lfsr16 u_lfsr (
      .in_clock  (in_clock),
      .in_reset  (in_reset),
      .in_seed   (in_seed),
      .in_step   (lfsrStep),
      .out_state (lfsrState)
   );

   assign curEntry  = segTable_q[idx_q];
   assign curWeight = TW'(curEntry.weight);
   assign lastIdx   = ({1'b0, idx_q} == (numSeg_q - ONE_N));

   // The target uses the value the LFSR will hold after this draw's step,
   // scaled so that it always lands in [0, total-1].
   assign drawProduct = {{TW{1'b0}}, lfsrNext(lfsrState)} * {16'd0, total_q};

   // Segment table: cleared on reset, writable only while no draw is active.
   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         for (int i = 0; i < MAX_SEGMENTS; i++) begin
            segTable_q[i] <= '0;
         end
      end else if (in_wr_en && (state_q == ST_IDLE)) begin
         segTable_q[in_wr_index] <= '{fromVal: in_wr_from,
                                      toVal:   in_wr_to,
                                      segType: seg_type_e'(in_wr_type),
                                      weight:  in_wr_weight};
      end
   end

   // Next-state logic: accumulate weights, draw a target, scan for the hit.
   always_comb begin
      state_d  = state_q;
      numSeg_d = numSeg_q;
      idx_d    = idx_q;
      total_d  = total_q;
      cum_d    = cum_q;
      target_d = target_q;
      error_d  = 1'b0;
      from_d   = from_q;
      to_d     = to_q;
      type_d   = type_q;
      weight_d = weight_q;
      index_d  = index_q;
      lfsrStep = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (in_start) begin
               if ((in_num_segments == '0) || (in_num_segments > MAX_N)) begin
                  error_d = 1'b1;
               end else begin
                  numSeg_d = in_num_segments;
                  idx_d    = '0;
                  total_d  = '0;
                  state_d  = ST_ACCUM;
               end
            end
         end

         ST_ACCUM: begin
            total_d = total_q + curWeight;
            if (lastIdx) begin
               idx_d = '0;
               if (total_d == '0) begin
                  error_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DRAW;
               end
            end else begin
               idx_d = idx_q + ONE_IDX;
            end
         end

         ST_DRAW: begin
            lfsrStep = 1'b1;
            target_d = TW'(drawProduct >> 16);
            cum_d    = '0;
            idx_d    = '0;
            state_d  = ST_SCAN;
         end

         ST_SCAN: begin
            cum_d = cum_q + curWeight;
            if (target_q < cum_d) begin
               from_d   = curEntry.fromVal;
               to_d     = curEntry.toVal;
               type_d   = curEntry.segType;
               weight_d = curEntry.weight;
               index_d  = idx_q;
               state_d  = ST_OUTPUT;
            end else if (lastIdx) begin
               state_d = ST_IDLE;
            end else begin
               idx_d = idx_q + ONE_IDX;
            end
         end

         ST_OUTPUT: begin
            if (in_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and result registers; reset aborts any draw in flight.
   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         state_q  <= ST_IDLE;
         numSeg_q <= '0;
         idx_q    <= '0;
         total_q  <= '0;
         cum_q    <= '0;
         target_q <= '0;
         error_q  <= 1'b0;
         from_q   <= '0;
         to_q     <= '0;
         type_q   <= SEG_NONE;
         weight_q <= '0;
         index_q  <= '0;
      end else begin
         state_q  <= state_d;
         numSeg_q <= numSeg_d;
         idx_q    <= idx_d;
         total_q  <= total_d;
         cum_q    <= cum_d;
         target_q <= target_d;
         error_q  <= error_d;
         from_q   <= from_d;
         to_q     <= to_d;
         type_q   <= type_d;
         weight_q <= weight_d;
         index_q  <= index_d;
      end
   end

   assign out_busy   = (state_q != ST_IDLE);
   assign out_valid  = (state_q == ST_OUTPUT);
   assign out_from   = from_q;
   assign out_to     = to_q;
   assign out_type   = type_q;
   assign out_weight = weight_q;
   assign out_index  = index_q;
   assign out_error  = error_q;

endmodule

// File: tb/tb_segment_selector.sv
// Self-checking bench for segment_selector: a reference model of the table
// and LFSR predicts each draw, pushes it to a scoreboard queue, and the
// result is popped and compared when the selector answers.
module tb_segment_selector;

   localparam int MAXS = 8;
   localparam int DW   = 8;

   logic                 in_clock = 1'b0;
   logic                 in_reset = 1'b0;
   logic [7:0]           in_seed = '0;
   logic                 in_wr_en = 1'b0;
   logic [2:0]           in_wr_index = '0;
   logic signed [DW-1:0] in_wr_from = '0;
   logic signed [DW-1:0] in_wr_to = '0;
   logic [1:0]           in_wr_type = '0;
   logic [DW-1:0]        in_wr_weight = '0;
   logic [3:0]           in_num_segments = '0;
   logic                 in_start = 1'b0;
   logic                 in_ready = 1'b0;
   logic                 out_busy;
   logic                 out_valid;
   logic signed [DW-1:0] out_from;
   logic signed [DW-1:0] out_to;
   logic [1:0]           out_type;
   logic signed [DW-1:0] out_weight;
   logic [2:0]           out_index;
   logic                 out_error;

   segment_selector #(
      .MAX_SEGMENTS (MAXS),
      .DATA_WIDTH   (DW)
   ) dut (
      .in_clock        (in_clock),
      .in_reset        (in_reset),
      .in_seed         (in_seed),
      .in_wr_en        (in_wr_en),
      .in_wr_index     (in_wr_index),
      .in_wr_from      (in_wr_from),
      .in_wr_to        (in_wr_to),
      .in_wr_type      (in_wr_type),
      .in_wr_weight    (in_wr_weight),
      .in_num_segments (in_num_segments),
      .in_start        (in_start),
      .in_ready        (in_ready),
      .out_busy        (out_busy),
      .out_valid       (out_valid),
      .out_from        (out_from),
      .out_to          (out_to),
      .out_type        (out_type),
      .out_weight      (out_weight),
      .out_index       (out_index),
      .out_error       (out_error)
   );

   // Free-running 100 MHz clock.
   always #5 in_clock = ~in_clock;

   typedef struct {
      int isErr;
      int lat;
      int idx;
      int from;
      int to;
      int typ;
      int weight;
   } expect_t;

   expect_t     sbQ[$];
   int          testsRun = 0;
   int          testsFailed = 0;
   int          mWeight[MAXS];
   int          mFrom[MAXS];
   int          mTo[MAXS];
   int          mType[MAXS];
   logic [15:0] mLfsr;
   int          recIdx[200];

   task automatic checkOutput(input string tag, input logic signed [31:0] actual,
                              input logic signed [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   function automatic logic [15:0] modelStep(input logic [15:0] s);
      logic fb;
      fb = s[15] ^ s[13] ^ s[12] ^ s[10];
      return {s[14:0], fb};
   endfunction

   function automatic int clampInt(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic modelReset(input logic [7:0] seed);
      for (int i = 0; i < MAXS; i++) begin
         mWeight[i] = 0;
         mFrom[i]   = 0;
         mTo[i]     = 0;
         mType[i]   = 0;
      end
      mLfsr = {((seed == 8'd0) ? 8'h01 : seed), 8'hA5};
   endtask

   task automatic applyReset(input logic [7:0] seed);
      in_seed  = seed;
      in_reset = 1'b1;
      @(posedge in_clock); #1;
      @(posedge in_clock); #1;
      in_reset = 1'b0;
      modelReset(seed);
   endtask

   task automatic writeEntry(input int idx, input int from, input int to,
                             input int typ, input int w);
      in_wr_en     = 1'b1;
      in_wr_index  = idx[2:0];
      in_wr_from   = from[DW-1:0];
      in_wr_to     = to[DW-1:0];
      in_wr_type   = typ[1:0];
      in_wr_weight = w[DW-1:0];
      @(posedge in_clock); #1;
      in_wr_en     = 1'b0;
      mWeight[idx] = w;
      mFrom[idx]   = from;
      mTo[idx]     = to;
      mType[idx]   = typ;
   endtask

   // Predict one draw, push it, start the DUT and compare when it answers.
   // holdCycles > 0 keeps in_ready low while start and table writes are
   // pulsed, then accepts with in_start still high.
   task automatic applyStimulus(input int n, input int holdCycles,
                                output int obsIdx, output int expIdx);
      expect_t e;
      int      total;
      int      cum;
      longint  target;
      int      edges;
      bit      seen;
      e = '{default: 0};
      e.idx = -1;
      if (n == 0 || n > MAXS) begin
         e.isErr = 1;
         e.lat   = 1;
      end else begin
         total = 0;
         for (int i = 0; i < n; i++) total += mWeight[i];
         if (total == 0) begin
            e.isErr = 1;
            e.lat   = n + 1;
         end else begin
            mLfsr  = modelStep(mLfsr);
            target = (longint'(mLfsr) * total) >> 16;
            cum    = 0;
            for (int i = 0; i < n; i++) begin
               cum += mWeight[i];
               if (e.idx < 0 && target < cum) e.idx = i;
            end
            e.lat    = n + 3 + e.idx;
            e.from   = mFrom[e.idx];
            e.to     = mTo[e.idx];
            e.typ    = mType[e.idx];
            e.weight = mWeight[e.idx];
         end
      end
      expIdx = e.idx;
      sbQ.push_back(e);

      in_num_segments = n[3:0];
      in_start = 1'b1;
      @(posedge in_clock); #1;
      in_start = 1'b0;
      edges = 1;
      checkOutput("busy_after_start", out_busy, (n >= 1 && n <= MAXS) ? 1 : 0);

      seen = 1'b0;
      while (!seen && edges < 64) begin
         if (out_valid || out_error) begin
            seen = 1'b1;
         end else begin
            @(posedge in_clock); #1;
            edges++;
         end
      end

      e = sbQ.pop_front();
      obsIdx = -1;
      checkOutput("result_seen", seen, 1);
      if (seen) begin
         checkOutput("latency", edges, e.lat);
         checkOutput("error_flag", out_error, e.isErr);
         checkOutput("valid_flag", out_valid, e.isErr ? 0 : 1);
         if (out_valid) begin
            obsIdx = out_index;
            checkOutput("index", out_index, e.idx);
            checkOutput("from", out_from, e.from);
            checkOutput("to", out_to, e.to);
            checkOutput("type", out_type, e.typ);
            checkOutput("weight", out_weight, e.weight);
            for (int h = 0; h < holdCycles; h++) begin
               in_start     = 1'b1;
               in_wr_en     = 1'b1;
               in_wr_index  = 3'd0;
               in_wr_from   = 8'sd99;
               in_wr_to     = 8'sd100;
               in_wr_type   = 2'd1;
               in_wr_weight = 8'd200;
               @(posedge in_clock); #1;
               checkOutput("hold_valid", out_valid, 1);
               checkOutput("hold_index", out_index, e.idx);
               checkOutput("hold_from", out_from, e.from);
               checkOutput("hold_weight", out_weight, e.weight);
            end
            in_wr_en = 1'b0;
            in_start = (holdCycles > 0);
            in_ready = 1'b1;
            @(posedge in_clock); #1;
            in_ready = 1'b0;
            in_start = 1'b0;
            checkOutput("accepted_valid", out_valid, 0);
            checkOutput("accepted_busy", out_busy, 0);
         end else begin
            @(posedge in_clock); #1;
            checkOutput("error_pulse_end", out_error, 0);
            checkOutput("error_no_valid", out_valid, 0);
         end
      end
   endtask

   initial begin
      int obs;
      int exp;
      int cnt1;

      applyReset(8'h5A);
      checkOutput("rst_busy", out_busy, 0);
      checkOutput("rst_valid", out_valid, 0);
      checkOutput("rst_error", out_error, 0);
      checkOutput("rst_from", out_from, 0);
      checkOutput("rst_to", out_to, 0);
      checkOutput("rst_type", out_type, 0);
      checkOutput("rst_weight", out_weight, 0);
      checkOutput("rst_index", out_index, 0);

      // Single active entry.
      writeEntry(0, -5, 10, 3, 5);
      applyStimulus(1, 0, obs, exp);

      // Only the middle entry carries weight.
      writeEntry(0, 1, 2, 1, 0);
      writeEntry(1, -20, 30, 2, 10);
      writeEntry(2, 3, 4, 3, 0);
      repeat (50) applyStimulus(3, 0, obs, exp);

      // Rejected draws: zero total, N=0, N above table depth.
      writeEntry(1, -20, 30, 2, 0);
      applyStimulus(2, 0, obs, exp);
      applyStimulus(0, 0, obs, exp);
      applyStimulus(9, 0, obs, exp);

      // Pending result held while start and writes are pulsed.
      writeEntry(1, -7, 7, 3, 10);
      applyStimulus(2, 5, obs, exp);
      applyStimulus(2, 0, obs, exp);

      // Reset in the middle of a scan.
      writeEntry(3, -9, 9, 2, 5);
      applyStimulus(4, 0, obs, exp);
      in_seed = 8'h00;
      in_num_segments = 4'd4;
      in_start = 1'b1;
      @(posedge in_clock); #1;
      in_start = 1'b0;
      repeat (5) begin
         @(posedge in_clock); #1;
      end
      checkOutput("scan_busy", out_busy, 1);
      checkOutput("scan_valid", out_valid, 0);
      #2 in_reset = 1'b1;
      @(posedge in_clock); #1;
      checkOutput("abort_busy", out_busy, 0);
      checkOutput("abort_valid", out_valid, 0);
      checkOutput("abort_from", out_from, 0);
      checkOutput("abort_to", out_to, 0);
      checkOutput("abort_type", out_type, 0);
      checkOutput("abort_weight", out_weight, 0);
      checkOutput("abort_index", out_index, 0);
      in_reset = 1'b0;
      modelReset(8'h00);
      repeat (10) begin
         @(posedge in_clock); #1;
      end
      checkOutput("abort_quiet_valid", out_valid, 0);
      checkOutput("abort_quiet_error", out_error, 0);
      applyStimulus(4, 0, obs, exp);
      for (int i = 0; i < 4; i++) writeEntry(i, i - 2, i + 5, 3 - (i % 3), 4);
      repeat (20) applyStimulus(4, 0, obs, exp);

      // Weighted distribution and reproducibility with a fixed seed.
      applyReset(8'h3C);
      writeEntry(0, -1, 1, 3, 1);
      writeEntry(1, 2, 9, 2, 3);
      cnt1 = 0;
      for (int i = 0; i < 4000; i++) begin
         applyStimulus(2, 0, obs, exp);
         if (obs == 1) cnt1++;
         if (i < 200) recIdx[i] = exp;
      end
      checkOutput("freq_idx1", cnt1, clampInt(cnt1, 2880, 3120));

      applyReset(8'h3C);
      writeEntry(0, -1, 1, 3, 1);
      writeEntry(1, 2, 9, 2, 3);
      for (int i = 0; i < 200; i++) begin
         applyStimulus(2, 0, obs, exp);
         checkOutput("repeat_seq", obs, recIdx[i]);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
